video_timing_gen: RTL

- Parametrised raster timing generator for the HDMI overlay path; successor to the fixed 12-bit HS/VS/DE generator.
- Produces HS/VS/DE with configurable polarity, plus pixel coordinates and frame/line strobes.
- Timing registers are double-buffered so the mode can change glitch-free at frame boundaries.
- Sits between the pixel clock domain and the overlay/pattern blocks, which consume x/y/de.

---
 rtl/video_timing_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with double-buffered mode registers
//
// Optional window output is built when VTG_OVERLAY_WIN_EN is defined.
//
// Ports:
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   en                    run enable; low forces counters to 0 and outputs idle
//   cfg_h_*/cfg_v_*       staged timing (total, sync width, active start, active end)
//   cfg_update            request to load the staged timing at the next frame end
//   cfg_ack               one-cycle pulse when the staged timing takes effect
//   vga_hs/vga_vs/vga_de  sync and display enable, all registered and aligned
//   pix_x/pix_y           active-area coordinates, 0 outside the active region
//   frame_start           first active pixel of a frame
//   line_start            first active pixel of each active line
//   win_x0..win_y1,win_de window bounds and in-window enable (VTG_OVERLAY_WIN_EN only)
module video_timing_gen #(
  parameter int unsigned CW          = 12,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned DEF_H_TOTAL = 799,
  parameter int unsigned DEF_H_SYNC  = 96,
  parameter int unsigned DEF_H_START = 144,
  parameter int unsigned DEF_H_END   = 784,
  parameter int unsigned DEF_V_TOTAL = 524,
  parameter int unsigned DEF_V_SYNC  = 2,
  parameter int unsigned DEF_V_START = 35,
  parameter int unsigned DEF_V_END   = 515
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_start,
  input  logic [CW-1:0] cfg_h_end,
  input  logic [CW-1:0] cfg_v_total,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_start,
  input  logic [CW-1:0] cfg_v_end,
  input  logic          cfg_update,
  output logic          cfg_ack,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_start
`ifdef VTG_OVERLAY_WIN_EN
  ,
  input  logic [CW-1:0] win_x0,
  input  logic [CW-1:0] win_y0,
  input  logic [CW-1:0] win_x1,
  input  logic [CW-1:0] win_y1,
  output logic          win_de
`endif
);

  logic [CW-1:0] hc_q, vc_q;
  logic [CW-1:0] h_total_q, h_sync_q, h_start_q, h_end_q;
  logic [CW-1:0] v_total_q, v_sync_q, v_start_q, v_end_q;
  logic          pending_q;

  logic          hs_q, vs_q, de_q, fs_q, ls_q, ack_q;
  logic [CW-1:0] px_q, py_q;

  logic          line_end, frame_end, apply;
  logic          hs_act, vs_act, de_d;
  logic [CW-1:0] px_d, py_d;

  always_comb begin
    line_end  = (hc_q == h_total_q);
    frame_end = line_end && (vc_q == v_total_q);
    // A request arriving on the frame-end cycle itself is honoured immediately.
    apply     = en && frame_end && (pending_q || cfg_update);
    hs_act    = (hc_q < h_sync_q);
    vs_act    = (vc_q < v_sync_q);
    de_d      = (hc_q >= h_start_q) && (hc_q < h_end_q) &&
                (vc_q >= v_start_q) && (vc_q < v_end_q);
    px_d      = de_d ? (hc_q - h_start_q) : '0;
    py_d      = de_d ? (vc_q - v_start_q) : '0;
  end

  // Raster counters and the active timing set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q      <= '0;
      vc_q      <= '0;
      pending_q <= 1'b0;
      h_total_q <= CW'(DEF_H_TOTAL);
      h_sync_q  <= CW'(DEF_H_SYNC);
      h_start_q <= CW'(DEF_H_START);
      h_end_q   <= CW'(DEF_H_END);
      v_total_q <= CW'(DEF_V_TOTAL);
      v_sync_q  <= CW'(DEF_V_SYNC);
      v_start_q <= CW'(DEF_V_START);
      v_end_q   <= CW'(DEF_V_END);
    end else begin
      if (!en) begin
        hc_q <= '0;
        vc_q <= '0;
      end else if (line_end) begin
        hc_q <= '0;
        vc_q <= frame_end ? '0 : vc_q + CW'(1);
      end else begin
        hc_q <= hc_q + CW'(1);
      end

      if (apply) begin
        h_total_q <= cfg_h_total;
        h_sync_q  <= cfg_h_sync;
        h_start_q <= cfg_h_start;
        h_end_q   <= cfg_h_end;
        v_total_q <= cfg_v_total;
        v_sync_q  <= cfg_v_sync;
        v_start_q <= cfg_v_start;
        v_end_q   <= cfg_v_end;
        pending_q <= 1'b0;
      end else if (cfg_update) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Output stage: one register for every output so they stay mutually aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      ls_q  <= 1'b0;
      ack_q <= 1'b0;
      px_q  <= '0;
      py_q  <= '0;
    end else begin
      ack_q <= apply;
      if (!en) begin
        hs_q <= ~HS_POL;
        vs_q <= ~VS_POL;
        de_q <= 1'b0;
        fs_q <= 1'b0;
        ls_q <= 1'b0;
        px_q <= '0;
        py_q <= '0;
      end else begin
        hs_q <= hs_act ? HS_POL : ~HS_POL;
        vs_q <= vs_act ? VS_POL : ~VS_POL;
        de_q <= de_d;
        fs_q <= de_d && (px_d == '0) && (py_d == '0);
        ls_q <= de_d && (px_d == '0);
        px_q <= px_d;
        py_q <= py_d;
      end
    end
  end

  assign cfg_ack     = ack_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

`ifdef VTG_OVERLAY_WIN_EN
  logic win_de_q;
  logic win_de_d;

  // Bounds are compared against the unregistered coordinates so win_de lines up with vga_de.
  always_comb begin
    win_de_d = de_d && (px_d >= win_x0) && (px_d < win_x1) &&
               (py_d >= win_y0) && (py_d < win_y1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_de_q <= 1'b0;
    end else begin
      win_de_q <= en && win_de_d;
    end
  end

  assign win_de = win_de_q;
`endif

endmodule
